// File: rtl/fetch_pkg.sv
// Shared types and bus constants for the instruction fetch unit.
// Holds the FSM state enum, AXI burst constants and the queue entry struct.
package fetch_pkg;

    localparam int         LINE_BYTES = 64;
    localparam logic [7:0] BURST_LEN  = 8'h07;
    localparam logic [2:0] SIZE_8B    = 3'b011;
    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DATA,
        ST_DRAIN
    } fetch_state_e;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Bus bundle of the fetch unit: AXI read channels (AR/R) and decode handshake.
// master = fetch unit side, slave = memory / decode side.
interface instr_fetch_if #(
    parameter int ID_WIDTH = 13
);

    logic [ID_WIDTH-1:0] m_axi_arid;
    logic [63:0]         m_axi_araddr;
    logic [7:0]          m_axi_arlen;
    logic [2:0]          m_axi_arsize;
    logic [1:0]          m_axi_arburst;
    logic                m_axi_arvalid;
    logic                m_axi_arready;
    logic [63:0]         m_axi_rdata;
    logic                m_axi_rvalid;
    logic                m_axi_rlast;
    logic                m_axi_rready;
    logic                inst_valid;
    logic                inst_ready;
    logic [31:0]         inst_data;
    logic [63:0]         inst_pc;

    modport master (
        output m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize,
        output m_axi_arburst, m_axi_arvalid, m_axi_rready,
        output inst_valid, inst_data, inst_pc,
        input  m_axi_arready, m_axi_rdata, m_axi_rvalid, m_axi_rlast,
        input  inst_ready
    );

    modport slave (
        input  m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize,
        input  m_axi_arburst, m_axi_arvalid, m_axi_rready,
        input  inst_valid, inst_data, inst_pc,
        output m_axi_arready, m_axi_rdata, m_axi_rvalid, m_axi_rlast,
        output inst_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Instruction queue: two write ports (wr0 then wr1 in order), one read port.
// Ports: clk, reset, flush, wr0/wr1 en+data, rd_en, rd_valid, rd_data, free.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     wr0_en,
    input  fetch_entry_t             wr0_data,
    input  logic                     wr1_en,
    input  fetch_entry_t             wr1_data,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output fetch_entry_t             rd_data,
    output logic [$clog2(DEPTH):0]   free
);

    localparam int AW = $clog2(DEPTH);

    typedef logic [AW:0] ptr_t;

    localparam ptr_t FULL = ptr_t'(DEPTH);

    fetch_entry_t mem [DEPTH];
    ptr_t         wptr;
    ptr_t         rptr;
    ptr_t         count;
    ptr_t         wptr1;
    logic         pop;

    assign count    = wptr - rptr;
    assign free     = FULL - count;
    assign rd_valid = (count != '0);
    assign rd_data  = mem[rptr[AW-1:0]];
    assign pop      = rd_en && rd_valid;

    // wr1 lands right behind wr0, or at the tail if wr0 is idle.
    assign wptr1 = wptr + ptr_t'(wr0_en);

    always_ff @(posedge clk) begin
        if (wr0_en && !flush) begin
            mem[wptr[AW-1:0]] <= wr0_data;
        end
        if (wr1_en && !flush) begin
            mem[wptr1[AW-1:0]] <= wr1_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            wptr <= wptr + ptr_t'(wr0_en) + ptr_t'(wr1_en);
            rptr <= rptr + ptr_t'(pop);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: fetches 64-byte lines over AXI, queues 32-bit words.
// Ports: clk, reset, entry, bus (AXI AR/R + decode), redirect_*, halt.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int ID_WIDTH   = 13,
    parameter int FIFO_DEPTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [63:0]   entry,
    instr_fetch_if.master bus,
    input  logic          redirect_valid,
    input  logic [63:0]   redirect_pc,
    output logic          halt
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] MIN_FREE = CW'(16);

    fetch_state_e  state;
    logic [63:0]   fetch_pc;
    logic [63:0]   ar_addr;
    logic          drop_burst;
    logic [2:0]    beat;

    logic [63:0]   line_base;
    logic [63:0]   redir_pc;
    logic          beat_hs;
    logic          ar_hs;
    logic [5:0]    off0;
    logic [5:0]    off1;
    logic          beat_ok;
    logic          wr0_en;
    logic          wr1_en;
    fetch_entry_t  wr0_data;
    fetch_entry_t  wr1_data;
    logic          q_valid;
    fetch_entry_t  q_head;
    logic [CW-1:0] q_free;
    logic          unused_bits;

    assign line_base = {fetch_pc[63:6], 6'b0};
    assign redir_pc  = {redirect_pc[63:2], 2'b00};
    assign beat_hs   = bus.m_axi_rvalid && bus.m_axi_rready;
    assign ar_hs     = bus.m_axi_arvalid && bus.m_axi_arready;
    assign off0      = {beat, 3'b000};
    assign off1      = {beat, 3'b100};

    // A beat is usable only in DATA, before any halt, and not on redirect.
    assign beat_ok = (state == ST_DATA) && beat_hs && !halt
                   && !redirect_valid && (bus.m_axi_rdata != 64'b0);

    // fetch_pc stays inside the line during DATA: offsets compare directly.
    assign wr0_en = beat_ok && (off0 >= fetch_pc[5:0]);
    assign wr1_en = beat_ok && (off1 >= fetch_pc[5:0]);

    assign wr0_data = '{pc: {fetch_pc[63:6], off0},
                        instr: bus.m_axi_rdata[31:0]};
    assign wr1_data = '{pc: {fetch_pc[63:6], off1},
                        instr: bus.m_axi_rdata[63:32]};

    assign unused_bits = ^{entry[1:0], redirect_pc[1:0]};

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect_valid),
        .wr0_en   (wr0_en),
        .wr0_data (wr0_data),
        .wr1_en   (wr1_en),
        .wr1_data (wr1_data),
        .rd_en    (bus.inst_ready),
        .rd_valid (q_valid),
        .rd_data  (q_head),
        .free     (q_free)
    );

    assign bus.inst_valid    = q_valid;
    assign bus.inst_data     = q_head.instr;
    assign bus.inst_pc       = q_head.pc;

    assign bus.m_axi_arid    = {ID_WIDTH{1'b0}};
    assign bus.m_axi_araddr  = ar_addr;
    assign bus.m_axi_arlen   = BURST_LEN;
    assign bus.m_axi_arsize  = SIZE_8B;
    assign bus.m_axi_arburst = BURST_INCR;
    assign bus.m_axi_arvalid = (state == ST_REQ);
    assign bus.m_axi_rready  = (state == ST_DATA) || (state == ST_DRAIN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            fetch_pc   <= {entry[63:2], 2'b00};
            ar_addr    <= '0;
            drop_burst <= 1'b0;
            beat       <= '0;
            halt       <= 1'b0;
        end else begin
            if (redirect_valid) begin
                fetch_pc <= redir_pc;
                halt     <= 1'b0;
            end
            unique case (state)
                ST_IDLE: begin
                    if (q_free >= MIN_FREE && !halt && !redirect_valid) begin
                        state      <= ST_REQ;
                        ar_addr    <= line_base;
                        drop_burst <= 1'b0;
                    end
                end
                ST_REQ: begin
                    // AR must stay up until accepted; a redirect only
                    // marks the burst for discarding.
                    if (redirect_valid) begin
                        drop_burst <= 1'b1;
                    end
                    if (ar_hs) begin
                        beat  <= '0;
                        state <= (drop_burst || redirect_valid)
                               ? ST_DRAIN : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (beat_hs) begin
                        beat <= beat + 3'd1;
                        if (bus.m_axi_rdata == 64'b0 && !redirect_valid) begin
                            halt <= 1'b1;
                        end
                        // A redirect on the last beat leaves nothing to drain.
                        if (bus.m_axi_rlast) begin
                            state <= ST_IDLE;
                            if (!redirect_valid) begin
                                fetch_pc <= {fetch_pc[63:6] + 58'd1, 6'b0};
                            end
                        end else if (redirect_valid) begin
                            state <= ST_DRAIN;
                        end
                    end else if (redirect_valid) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (beat_hs && bus.m_axi_rlast) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: stall-free AXI memory model plus pop scoreboard.
// Directed scenarios: aligned/unaligned entry, backpressure, redirect, halt.
module tb_instr_fetch;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] entry = 64'h0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        halt;

    int t_run = 0;
    int t_fail = 0;
    int pop_cnt = 0;

    fetch_entry_t exp_q[$];
    logic [63:0]  ar_log[$];

    logic        mm_busy = 1'b0;
    int          mm_beat = 0;
    logic [63:0] mm_addr = 64'h0;
    logic        zero_en = 1'b0;
    logic [63:0] zero_addr = 64'h0;

    instr_fetch_if #(.ID_WIDTH(13)) bus ();

    instr_fetch #(
        .ID_WIDTH   (13),
        .FIFO_DEPTH (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .entry          (entry),
        .bus            (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [63:0] a);
        return a[31:0] ^ 32'hA5A5_0013;
    endfunction

    function automatic logic [63:0] beat_data(input logic [63:0] a);
        if (zero_en && a == zero_addr) return 64'h0;
        return {word(a + 64'd4), word(a)};
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        t_run++;
        if (act !== req) begin
            t_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic push_lin(input logic [63:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            logic [63:0] pc;
            pc = start + 64'(4 * i);
            exp_q.push_back('{pc: pc, instr: word(pc)});
        end
    endtask

    // Memory model: AR always ready, one beat per cycle, no stalls.
    initial begin
        logic ar_fire;
        logic r_fire;
        bus.m_axi_arready = 1'b1;
        bus.m_axi_rvalid = 1'b0;
        bus.m_axi_rlast = 1'b0;
        bus.m_axi_rdata = 64'h0;
        forever begin
            @(negedge clk);
            ar_fire = bus.m_axi_arvalid && bus.m_axi_arready;
            r_fire = bus.m_axi_rvalid && bus.m_axi_rready;
            if (ar_fire) begin
                check("arlen", 64'(bus.m_axi_arlen), 64'h7);
                check("arsize", 64'(bus.m_axi_arsize), 64'h3);
                check("arburst", 64'(bus.m_axi_arburst), 64'h1);
                check("arid", 64'(bus.m_axi_arid), 64'h0);
            end
            @(posedge clk);
            #1;
            if (reset) begin
                mm_busy = 1'b0;
                bus.m_axi_rvalid = 1'b0;
                bus.m_axi_rlast = 1'b0;
            end else begin
                if (r_fire) begin
                    if (mm_beat == 7) mm_busy = 1'b0;
                    else mm_beat++;
                end
                if (ar_fire) begin
                    ar_log.push_back(bus.m_axi_araddr);
                    mm_busy = 1'b1;
                    mm_beat = 0;
                    mm_addr = bus.m_axi_araddr;
                end
                bus.m_axi_rvalid = mm_busy;
                bus.m_axi_rlast = mm_busy && (mm_beat == 7);
                bus.m_axi_rdata = beat_data(mm_addr + 64'(8 * mm_beat));
            end
        end
    end

    // Monitor: every completed decode transfer is checked against the queue.
    initial begin
        fetch_entry_t e;
        forever begin
            @(negedge clk);
            if (bus.inst_valid && bus.inst_ready) begin
                pop_cnt++;
                if (exp_q.size() == 0) begin
                    t_run++;
                    t_fail++;
                    $display("FAIL pop_unexpected actual=%h required=none",
                             bus.inst_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_pc", bus.inst_pc, e.pc);
                    check("pop_data", 64'(bus.inst_data), 64'(e.instr));
                end
            end
        end
    end

    task automatic do_reset(input logic [63:0] e);
        bus.inst_ready = 1'b0;
        redirect_valid = 1'b0;
        @(posedge clk);
        #2;
        entry = e;
        reset = 1'b1;
        @(posedge clk);
        #2;
        check("rst_arvalid", 64'(bus.m_axi_arvalid), 64'h0);
        check("rst_rready", 64'(bus.m_axi_rready), 64'h0);
        check("rst_inst_valid", 64'(bus.inst_valid), 64'h0);
        check("rst_halt", 64'(halt), 64'h0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        exp_q.delete();
        ar_log.delete();
        pop_cnt = 0;
    endtask

    task automatic wait_pops(input string name, input int n);
        int i;
        for (i = 0; i < 300 && pop_cnt < n; i++) begin
            @(posedge clk);
            #2;
        end
        if (pop_cnt < n) check(name, 64'(pop_cnt), 64'(n));
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_redirect(input logic [63:0] pc);
        redirect_pc = pc;
        redirect_valid = 1'b1;
        @(posedge clk);
        #2;
        redirect_valid = 1'b0;
    endtask

    initial begin
        bus.inst_ready = 1'b0;

        // Aligned entry: one full line in order, then the next line.
        do_reset(64'h8000_0000);
        push_lin(64'h8000_0000, 40);
        bus.inst_ready = 1'b1;
        wait_pops("t1_pops", 20);
        bus.inst_ready = 1'b0;
        check("t1_ar0", ar_log.size() > 0 ? ar_log[0] : 64'hx, 64'h8000_0000);
        check("t1_ar1", ar_log.size() > 1 ? ar_log[1] : 64'hx, 64'h8000_0040);

        // Entry near the end of a line: only the last two words emitted.
        do_reset(64'h8000_0038);
        push_lin(64'h8000_0038, 30);
        bus.inst_ready = 1'b1;
        wait_pops("t2_pops", 6);
        bus.inst_ready = 1'b0;
        check("t2_ar0", ar_log.size() > 0 ? ar_log[0] : 64'hx, 64'h8000_0000);
        check("t2_ar1", ar_log.size() > 1 ? ar_log[1] : 64'hx, 64'h8000_0040);

        // Backpressure: queue fills to 32, no third request while full.
        do_reset(64'h8000_0000);
        push_lin(64'h8000_0000, 60);
        cycles(40);
        check("t3_ar_count", 64'(ar_log.size()), 64'd2);
        check("t3_head_valid", 64'(bus.inst_valid), 64'h1);
        check("t3_head_pc", bus.inst_pc, 64'h8000_0000);
        check("t3_no_pops", 64'(pop_cnt), 64'd0);
        bus.inst_ready = 1'b1;
        wait_pops("t3_pops", 40);
        bus.inst_ready = 1'b0;
        check("t3_ar2", ar_log.size() > 2 ? ar_log[2] : 64'hx, 64'h8000_0080);

        // Redirect presented with beat 3 of the first burst.
        do_reset(64'h8000_0000);
        push_lin(64'h8000_0000, 6);
        bus.inst_ready = 1'b1;
        begin
            int i;
            for (i = 0; i < 100 && !(bus.m_axi_rvalid && mm_beat == 3); i++) begin
                @(posedge clk);
                #2;
            end
            check("t4_beat3_seen", 64'(bus.m_axi_rvalid && mm_beat == 3), 64'h1);
        end
        pulse_redirect(64'h8000_1004);
        check("t4_flush_valid", 64'(bus.inst_valid), 64'h0);
        exp_q.delete();
        pop_cnt = 0;
        push_lin(64'h8000_1004, 30);
        wait_pops("t4_pops", 8);
        bus.inst_ready = 1'b0;
        check("t4_ar_count_ge2", 64'(ar_log.size() >= 2), 64'h1);
        check("t4_ar1", ar_log.size() > 1 ? ar_log[1] : 64'hx, 64'h8000_1000);

        // Zero beat 5: ten words, halt, burst consumed, no new request.
        zero_en = 1'b1;
        zero_addr = 64'h8000_0028;
        do_reset(64'h8000_0000);
        push_lin(64'h8000_0000, 10);
        bus.inst_ready = 1'b1;
        cycles(40);
        check("t5_halt", 64'(halt), 64'h1);
        check("t5_pops", 64'(pop_cnt), 64'd10);
        check("t5_rvalid", 64'(bus.m_axi_rvalid), 64'h0);
        check("t5_ar_count", 64'(ar_log.size()), 64'd1);
        zero_en = 1'b0;
        push_lin(64'h8000_0100, 30);
        pulse_redirect(64'h8000_0100);
        check("t5_halt_clr", 64'(halt), 64'h0);
        pop_cnt = 0;
        wait_pops("t5_resume_pops", 8);
        bus.inst_ready = 1'b0;
        check("t5_ar1", ar_log.size() > 1 ? ar_log[1] : 64'hx, 64'h8000_0100);

        cycles(4);
        $display("[TB] %0d tests run, %0d failed", t_run, t_fail);
        $finish;
    end

endmodule
